// File: rtl/mux_pkg.sv
// Shared constants for the registered N:1 multiplexer family.
// Holds the scan FSM state encoding and the mode select values.
package mux_pkg;

  typedef enum logic [1:0] {
    ST_DIRECT    = 2'd0,
    ST_SCAN_CAP  = 2'd1,
    ST_SCAN_WAIT = 2'd2
  } mux_state_t;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage : mux_pkg

// File: rtl/mux_nto1.sv
// Combinational N:1 slice selector; out-of-range selects clamp to the last channel.
// out_ch reports the channel actually driven onto out_data.
module mux_nto1 #(
  parameter int unsigned NUM_CH = 8,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned SEL_W  = 3
) (
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic [SEL_W-1:0]         sel,
  output logic [DATA_W-1:0]        out_data,
  output logic [SEL_W-1:0]         out_ch
);

  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(NUM_CH - 1);

  logic [SEL_W-1:0] w_idx;

  assign w_idx  = (sel > LAST_CH) ? LAST_CH : sel;
  assign out_ch = w_idx;

  // One-hot compare avoids a variable part-select on the packed bus
  always_comb begin
    out_data = '0;
    for (int k = 0; k < int'(NUM_CH); k++) begin
      if (w_idx == SEL_W'(k)) begin
        out_data = in_data[k*DATA_W +: DATA_W];
      end
    end
  end

endmodule : mux_nto1

// File: rtl/mux_scan_reg.sv
// Registered N-channel multiplexer with direct-select and round-robin scan modes.
// A single output stage with valid/ready handshake; a new capture may replace a sample being accepted.
module mux_scan_reg
  import mux_pkg::*;
#(
  parameter int unsigned NUM_CH  = 8,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned SEL_W   = 3,
  parameter int unsigned DWELL_W = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic                     mode,
  input  logic [SEL_W-1:0]         sel,
  input  logic                     sel_valid,
  input  logic [DWELL_W-1:0]       dwell,
  output logic [DATA_W-1:0]        out_data,
  output logic [SEL_W-1:0]         out_ch,
  output logic                     out_valid,
  input  logic                     out_ready
);

  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(NUM_CH - 1);

  mux_state_t         r_state;
  mux_state_t         w_state_nxt;
  logic [SEL_W-1:0]   r_ptr;
  logic [SEL_W-1:0]   w_ptr_nxt;
  logic [DWELL_W-1:0] r_cnt;
  logic [DWELL_W-1:0] w_cnt_nxt;

  logic [DATA_W-1:0]  r_out_data;
  logic [SEL_W-1:0]   r_out_ch;
  logic               r_out_valid;

  logic               w_slot_free;
  logic               w_cap;
  logic [SEL_W-1:0]   w_cap_sel;
  logic [DATA_W-1:0]  w_mux_data;
  logic [SEL_W-1:0]   w_mux_ch;

  assign w_slot_free = !r_out_valid || out_ready;

  mux_nto1 #(
    .NUM_CH (NUM_CH),
    .DATA_W (DATA_W),
    .SEL_W  (SEL_W)
  ) u_sel (
    .in_data  (in_data),
    .sel      (w_cap_sel),
    .out_data (w_mux_data),
    .out_ch   (w_mux_ch)
  );

  // Next-state, scan pointer, dwell counter and capture request
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_cnt;
    w_cap       = 1'b0;
    w_cap_sel   = r_ptr;

    case (r_state)
      ST_DIRECT: begin
        if (mode == MODE_SCAN) begin
          w_state_nxt = ST_SCAN_CAP;
          w_ptr_nxt   = '0;
          w_cnt_nxt   = '0;
        end else begin
          w_cap_sel = sel;
          w_cap     = sel_valid && w_slot_free;
        end
      end

      ST_SCAN_CAP: begin
        if (mode == MODE_DIRECT) begin
          w_state_nxt = ST_DIRECT;
        end else if (w_slot_free) begin
          w_cap     = 1'b1;
          w_ptr_nxt = (r_ptr == LAST_CH) ? '0 : r_ptr + 1'b1;
          if (dwell != '0) begin
            w_cnt_nxt   = dwell;
            w_state_nxt = ST_SCAN_WAIT;
          end
        end
      end

      ST_SCAN_WAIT: begin
        if (mode == MODE_DIRECT) begin
          w_state_nxt = ST_DIRECT;
        end else if (r_cnt <= DWELL_W'(1)) begin
          w_cnt_nxt   = '0;
          w_state_nxt = ST_SCAN_CAP;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end

      default: begin
        w_state_nxt = ST_DIRECT;
      end
    endcase
  end

  // Control state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_DIRECT;
      r_ptr   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Output stage: capture wins over drain so a handshake plus capture keeps valid high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_data  <= '0;
      r_out_ch    <= '0;
      r_out_valid <= 1'b0;
    end else if (w_cap) begin
      r_out_data  <= w_mux_data;
      r_out_ch    <= w_mux_ch;
      r_out_valid <= 1'b1;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_data  = r_out_data;
  assign out_ch    = r_out_ch;
  assign out_valid = r_out_valid;

endmodule : mux_scan_reg

// File: tb/tb_mux_scan_reg.sv
// Self-checking bench for mux_scan_reg: scoreboarded handshakes plus direct timing checks.
// A second 6-channel instance covers the out-of-range clamp.
`timescale 1ns/1ps
module tb_mux_scan_reg;

  typedef struct packed {
    logic [2:0] ch;
    logic [7:0] data;
  } sb_item_t;

  logic        clk;
  logic        rst_n;
  logic [63:0] in_data;
  logic        mode;
  logic [2:0]  sel;
  logic        sel_valid;
  logic [3:0]  dwell;
  logic [7:0]  out_data;
  logic [2:0]  out_ch;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  base;

  logic [47:0] in_data6;
  logic [2:0]  sel6;
  logic        sel_valid6;
  logic [7:0]  out_data6;
  logic [2:0]  out_ch6;
  logic        out_valid6;

  sb_item_t sb_q[$];
  int n_tests;
  int n_fail;

  mux_scan_reg #(.NUM_CH(8), .DATA_W(8), .SEL_W(3), .DWELL_W(4)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .mode      (mode),
    .sel       (sel),
    .sel_valid (sel_valid),
    .dwell     (dwell),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  mux_scan_reg #(.NUM_CH(6), .DATA_W(8), .SEL_W(3), .DWELL_W(4)) u_dut6 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data6),
    .mode      (1'b0),
    .sel       (sel6),
    .sel_valid (sel_valid6),
    .dwell     (4'd0),
    .out_data  (out_data6),
    .out_ch    (out_ch6),
    .out_valid (out_valid6),
    .out_ready (1'b1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    for (int k = 0; k < 8; k++) in_data[k*8 +: 8] = base + 8'(k);
    for (int k = 0; k < 6; k++) in_data6[k*8 +: 8] = 8'hA0 + 8'(k);
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, req, $time);
    end
  endtask

  task automatic push(input int ch);
    sb_item_t it;
    it.ch   = 3'(ch);
    it.data = 8'h10 + 8'(ch);
    sb_q.push_back(it);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Every accepted output must match the oldest expected capture
  always @(negedge clk) begin
    sb_item_t it;
    if (rst_n && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        check("sb_underflow", 32'd1, 32'd0);
      end else begin
        it = sb_q.pop_front();
        check("sb_ch", 32'(out_ch), 32'(it.ch));
        check("sb_data", 32'(out_data), 32'(it.data));
      end
    end
  end

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    rst_n      = 1'b0;
    base       = 8'h10;
    mode       = 1'b0;
    sel        = '0;
    sel_valid  = 1'b0;
    dwell      = '0;
    out_ready  = 1'b0;
    sel6       = '0;
    sel_valid6 = 1'b0;

    #3;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_ch", 32'(out_ch), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Direct capture of channel 3
    sel = 3'd3; sel_valid = 1'b1; out_ready = 1'b1;
    push(3);
    tick();
    check("dir_valid", 32'(out_valid), 32'd1);
    check("dir_data", 32'(out_data), 32'h13);
    check("dir_ch", 32'(out_ch), 32'd3);
    sel_valid = 1'b0;
    tick();
    check("drain_valid", 32'(out_valid), 32'd0);
    check("drain_hold", 32'(out_data), 32'h13);

    // Backpressure: output holds while inputs change
    sel = 3'd2; sel_valid = 1'b1; out_ready = 1'b0;
    push(2);
    tick();
    for (int i = 0; i < 4; i++) begin
      sel  = 3'(i + 4);
      base = 8'h40 + 8'(i * 4);
      tick();
      check("bp_data", 32'(out_data), 32'h12);
      check("bp_ch", 32'(out_ch), 32'd2);
      check("bp_valid", 32'(out_valid), 32'd1);
    end
    base = 8'h10; sel = 3'd5; out_ready = 1'b1;
    push(5);
    tick();
    check("bp_next_valid", 32'(out_valid), 32'd1);
    check("bp_next_ch", 32'(out_ch), 32'd5);
    check("bp_next_data", 32'(out_data), 32'h15);
    sel_valid = 1'b0;
    tick();
    check("bp_drain", 32'(out_valid), 32'd0);

    // Scan with zero dwell: one capture per cycle, wrapping
    dwell = 4'd0; mode = 1'b1;
    for (int i = 0; i < 10; i++) push(i % 8);
    tick();
    check("scan0_switch", 32'(out_valid), 32'd0);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("scan0_valid", 32'(out_valid), 32'd1);
      check("scan0_ch", 32'(out_ch), 32'(i % 8));
      check("scan0_data", 32'(out_data), 32'(8'h10 + 8'(i % 8)));
    end
    mode = 1'b0;
    tick();
    check("scan0_exit", 32'(out_valid), 32'd0);

    // Scan with dwell 2: captures three cycles apart
    dwell = 4'd2; mode = 1'b1;
    push(0); push(1); push(2);
    tick();
    for (int c = 0; c < 7; c++) begin
      tick();
      if (c % 3 == 0) begin
        check("scan2_valid", 32'(out_valid), 32'd1);
        check("scan2_ch", 32'(out_ch), 32'(c / 3));
      end else begin
        check("scan2_gap", 32'(out_valid), 32'd0);
      end
    end
    mode = 1'b0;
    tick();
    check("scan2_exit", 32'(out_valid), 32'd0);

    // Out-of-range select on the 6-channel instance
    sel6 = 3'd7; sel_valid6 = 1'b1;
    tick();
    check("oor7_ch", 32'(out_ch6), 32'd5);
    check("oor7_data", 32'(out_data6), 32'hA5);
    sel6 = 3'd2;
    tick();
    check("in6_ch", 32'(out_ch6), 32'd2);
    check("in6_data", 32'(out_data6), 32'hA2);
    sel6 = 3'd6;
    tick();
    check("oor6_ch", 32'(out_ch6), 32'd5);
    check("oor6_data", 32'(out_data6), 32'hA5);
    sel_valid6 = 1'b0;
    tick();

    // Async reset while channel 4 is being presented
    dwell = 4'd0; mode = 1'b1;
    for (int i = 0; i < 4; i++) push(i);
    tick();
    repeat (5) tick();
    check("pre_rst_ch", 32'(out_ch), 32'd4);
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_data", 32'(out_data), 32'd0);
    check("arst_ch", 32'(out_ch), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    push(0);
    tick();
    check("post_rst_valid", 32'(out_valid), 32'd1);
    check("post_rst_ch", 32'(out_ch), 32'd0);
    check("post_rst_data", 32'(out_data), 32'h10);
    mode = 1'b0;
    tick();
    tick();
    check("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_mux_scan_reg

// File: doc/mux_scan_reg.md
Name: mux_scan_reg

Overview:
- Parametrised N-channel, W-bit registered multiplexer; successor to the fixed 8:1 combinational selector.
- Two modes: direct (per-request select) and scan (auto round-robin over all channels with a programmable dwell gap).
- Output is a single registered stage with a valid/ready handshake.
- Sits between parallel sensor/data sources and a single serial consumer.

Parameters:
- NUM_CH, 8, number of input channels (>=2).
- DATA_W, 8, width of each channel.
- SEL_W, 3, select width; must satisfy 2**SEL_W >= NUM_CH.
- DWELL_W, 4, width of the dwell-gap field.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_data  in  NUM_CH*DATA_W  packed channels; channel k at bits [k*DATA_W +: DATA_W].
- mode  in  1  0 = direct, 1 = scan.
- sel  in  SEL_W  channel select, direct mode.
- sel_valid  in  1  direct-mode capture request.
- dwell  in  DWELL_W  idle cycles between scan captures.
- out_data  out  DATA_W  registered sample.
- out_ch  out  SEL_W  channel index of out_data.
- out_valid  out  1  out_data/out_ch valid.
- out_ready  in  1  consumer accepts when out_valid & out_ready.

Behaviour:
- Reset (async assert, sync deassert by the integrator): out_data=0, out_ch=0, out_valid=0, scan pointer=0, dwell counter=0, FSM=ST_DIRECT.
- Clock and reset naming: one clock, clk; reset rst_n, asynchronous, active-low.
- Slot free: slot_free = !out_valid | out_ready. A capture happens only when slot_free.
- Capture: out_data <= in_data[ch]; out_ch <= ch; out_valid <= 1.
- Latency: sample is visible one cycle after capture. Back-to-back throughput is 1 per cycle with out_ready held high.
- Hold: when out_valid & !out_ready, out_data, out_ch and out_valid hold stable. The in_data value is not re-sampled.
- Drain: on handshake with no new capture, out_valid <= 0 and out_data holds its last value.
- Out-of-range select: sel >= NUM_CH selects channel NUM_CH-1, and out_ch reports NUM_CH-1. This matches the legacy default arm.
- FSM states:
  - ST_DIRECT: capture on sel_valid & slot_free. When mode=1 -> ST_SCAN_CAP, with pointer=0 and dwell counter=0.
  - ST_SCAN_CAP:
    - When slot_free: capture channel=pointer.
    - Pointer advances, wrapping NUM_CH-1 -> 0.
    - If dwell==0, stay in ST_SCAN_CAP; otherwise load counter=dwell and go to ST_SCAN_WAIT.
    - When !slot_free: stall with pointer unchanged.
  - ST_SCAN_WAIT: decrement the counter each cycle; at counter==1 -> ST_SCAN_CAP. No capture occurs in this state.
- Mode 0 seen in any scan state -> ST_DIRECT next cycle. An in-flight output is unaffected. sel_valid is ignored on the switching cycle.
- dwell is sampled only at load; later changes apply at the next load.
- Simultaneous handshake and capture in the same cycle: the new sample replaces the old, and out_valid stays 1.
- Reset mid-transfer: out_valid drops immediately (async). The consumer must treat this as a discard.

Decomposition:
- Shared package mux_pkg holds:
  - state enum constants ST_DIRECT=2'd0, ST_SCAN_CAP=2'd1, ST_SCAN_WAIT=2'd2;
  - MODE_DIRECT / MODE_SCAN.
- Sub-module mux_nto1: a purely combinational parametrised N:1 slice selector with clamp-to-last-channel on out-of-range. It is reused by other blocks.
- The FSM, counters and output register live in mux_scan_reg.

Test Plan:
- Reset then direct capture: NUM_CH=8, DATA_W=8, in_data channel k = 8'h10+k, sel=3, sel_valid=1, out_ready=1 -> next cycle out_data=8'h13, out_ch=3, out_valid=1.
- Backpressure: out_ready=0 after capture of ch2 (8'h12), change in_data and sel for 4 cycles -> out_data stays 8'h12, out_ch=2, out_valid=1. Raise out_ready -> handshake, and the next capture proceeds.
- Scan, dwell=0, out_ready=1: mode=1 -> out_ch sequence 0,1,...,7,0,1 on consecutive cycles, with data 8'h10..8'h17, wrapping.
- Scan, dwell=2: captures spaced 3 cycles apart (capture, wait, wait). out_valid is high one cycle per sample, out_ch 0,1,2.
- Out-of-range: NUM_CH=6, SEL_W=3, sel=7 -> out_ch=5, out_data=channel 5 value.
- Async reset mid-scan: assert rst_n=0 between clocks while out_valid=1 at pointer 4 -> out_valid=0 and out_data=0 immediately. After release with mode=1, the first scan capture is channel 0.
